// File: rtl/priority_scanner.sv
// rtl/priority_scanner.sv - sequential priority scanner: one set-bit index per beat
//
// Purpose:
//   Accepts a WIDTH-bit request vector on a valid/ready handshake and emits
//   the index of every set bit, one per output beat, clearing each bit as it
//   is taken. A zero vector yields one beat flagged out_none.
//   Default order is lowest index first. Defining PRIORITY_SCANNER_MSB_FIRST_EN
//   switches to highest index first; ports and timing do not change.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request vector present on in_vec
//   in_ready   scanner idle and able to accept a vector
//   in_vec     request vector, bit i set = request i pending
//   out_valid  out_pos/out_last/out_none are valid
//   out_ready  consumer takes the current beat
//   out_pos    index of the current selected set bit of the residual
//   out_last   current beat is the final beat for this vector
//   out_none   accepted vector was all-zero; beat carries no index
//   busy       scanner is not idle

module priority_scanner #(
   parameter  int WIDTH = 16,
   localparam int IDXW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_pos,
   output logic             out_last,
   output logic             out_none,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      NONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state, state_n;
   logic [WIDTH-1:0] residual, residual_n;
   logic [WIDTH-1:0] residual_clr;
   logic [IDXW-1:0]  scan_pos;
   logic             single;

   // Priority decode of the registered residual. The loop runs away from the
   // winning end so the last hit seen is the one selected.
   always_comb begin
      scan_pos = '0;
`ifdef PRIORITY_SCANNER_MSB_FIRST_EN
      for (int i = 0; i < WIDTH; i++) begin
         if (residual[i]) scan_pos = IDXW'(i);
      end
`else
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (residual[i]) scan_pos = IDXW'(i);
      end
`endif
   end

   // Exactly one bit set: clearing the lowest set bit leaves nothing.
   assign single = (residual != '0) && ((residual & (residual - ONE)) == '0);

   always_comb begin
      residual_clr           = residual;
      residual_clr[scan_pos] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         residual <= '0;
      end else begin
         state    <= state_n;
         residual <= residual_n;
      end
   end

   always_comb begin
      state_n    = state;
      residual_n = residual;
      out_valid  = 1'b0;
      out_pos    = '0;
      out_last   = 1'b0;
      out_none   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (in_vec != '0) begin
                  residual_n = in_vec;
                  state_n    = SCAN;
               end else begin
                  state_n    = NONE;
               end
            end
         end
         SCAN: begin
            out_valid = 1'b1;
            out_pos   = scan_pos;
            out_last  = single;
            if (out_ready) begin
               // Final beat clears the only remaining bit, so residual ends at 0.
               residual_n = residual_clr;
               if (single) state_n = IDLE;
            end
         end
         NONE: begin
            out_valid = 1'b1;
            out_none  = 1'b1;
            out_last  = 1'b1;
            if (out_ready) state_n = IDLE;
         end
         default: begin
            state_n    = IDLE;
            residual_n = '0;
         end
      endcase
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_priority_scanner.sv
// tb/tb_priority_scanner.sv - self-checking bench for priority_scanner

module tb_priority_scanner;

   localparam int WIDTH = 16;
   localparam int IDXW  = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_vec = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [IDXW-1:0]  out_pos;
   logic             out_last;
   logic             out_none;
   logic             busy;

   priority_scanner #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pos   (out_pos),
      .out_last  (out_last),
      .out_none  (out_none),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: queue of beats still owed for the current vector; -1 = none beat.
   int q[$];
   // Beats observed being taken by the consumer.
   int got_pos[$];
   int got_last[$];

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void push_vector(logic [WIDTH-1:0] v);
      if (v == '0) begin
         q.push_back(-1);
      end else begin
`ifdef PRIORITY_SCANNER_MSB_FIRST_EN
         for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) q.push_back(i);
`else
         for (int i = 0; i < WIDTH; i++) if (v[i]) q.push_back(i);
`endif
      end
   endfunction

   function automatic void check_outputs();
      int has;
      has = (q.size() != 0) ? 1 : 0;
      chk("out_valid", int'(out_valid), has);
      chk("in_ready",  int'(in_ready),  1 - has);
      chk("busy",      int'(busy),      has);
      if (has != 0) begin
         chk("out_pos",  int'(out_pos),  (q[0] < 0) ? 0 : q[0]);
         chk("out_last", int'(out_last), (q.size() == 1) ? 1 : 0);
         chk("out_none", int'(out_none), (q[0] < 0) ? 1 : 0);
      end else begin
         chk("idle_pos",  int'(out_pos),  0);
         chk("idle_last", int'(out_last), 0);
         chk("idle_none", int'(out_none), 0);
      end
   endfunction

   // One clock: decide what the model does at the edge from pre-edge inputs,
   // apply it at the edge, then compare on the falling edge.
   task automatic step();
      bit acc, take;
      acc  = in_valid && (q.size() == 0);
      take = (q.size() != 0) && out_ready;
      if (out_valid && out_ready) begin
         got_pos.push_back(int'(out_pos));
         got_last.push_back(int'(out_last));
      end
      @(posedge clk);
      if (take) void'(q.pop_front());
      if (acc) push_vector(in_vec);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic async_reset();
      rst = 1'b1;
      #1;
      q.delete();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready",  int'(in_ready),  1);
      chk("rst_busy",      int'(busy),      0);
      chk("rst_out_pos",   int'(out_pos),   0);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain(int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", int'(q.size() != 0), 0);
   endtask

   task automatic send(logic [WIDTH-1:0] v);
      in_valid = 1'b1;
      in_vec   = v;
      step();
      in_valid = 1'b0;
   endtask

   int exp_8421[4];
   int exp_0006[2];

   initial begin
`ifdef PRIORITY_SCANNER_MSB_FIRST_EN
      exp_8421 = '{15, 10, 5, 0};
      exp_0006 = '{2, 1};
`else
      exp_8421 = '{0, 5, 10, 15};
      exp_0006 = '{1, 2};
`endif

      // Reset state while rst is held.
      @(negedge clk);
      @(negedge clk);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_in_ready",  int'(in_ready),  1);
      chk("reset_busy",      int'(busy),      0);
      chk("reset_out_pos",   int'(out_pos),   0);
      rst = 1'b0;
      @(negedge clk);
      check_outputs();

      // Zero vector: single none beat.
      out_ready = 1'b1;
      send(16'h0000);
      chk("zero_none", int'(out_none), 1);
      chk("zero_last", int'(out_last), 1);
      chk("zero_pos",  int'(out_pos),  0);
      step();
      chk("zero_idle", int'(in_ready), 1);

      // 0x8421 with out_ready high: four consecutive beats.
      got_pos.delete(); got_last.delete();
      send(16'h8421);
      drain(20);
      chk("b8421_count", got_pos.size(), 4);
      for (int i = 0; i < 4 && i < got_pos.size(); i++) begin
         chk("b8421_pos",  got_pos[i],  exp_8421[i]);
         chk("b8421_last", got_last[i], (i == 3) ? 1 : 0);
      end
      chk("b8421_busy_after", int'(busy), 0);

      // 0x0006 with three stalled cycles.
      got_pos.delete(); got_last.delete();
      out_ready = 1'b0;
      send(16'h0006);
      for (int i = 0; i < 3; i++) begin
         chk("stall_pos", int'(out_pos), exp_0006[0]);
         chk("stall_valid", int'(out_valid), 1);
         if (i < 2) step();
      end
      out_ready = 1'b1;
      drain(20);
      chk("b0006_count", got_pos.size(), 2);
      for (int i = 0; i < 2 && i < got_pos.size(); i++) begin
         chk("b0006_pos",  got_pos[i],  exp_0006[i]);
         chk("b0006_last", got_last[i], (i == 1) ? 1 : 0);
      end

      // 0xFFFF then 0x0001 held while busy: second vector waits for idle.
      got_pos.delete(); got_last.delete();
      in_valid = 1'b1;
      in_vec   = 16'hFFFF;
      step();
      in_vec   = 16'h0001;
      for (int i = 0; i < 40 && got_pos.size() < 17; i++) step();
      in_valid = 1'b0;
      drain(20);
      chk("bffff_count", got_pos.size(), 17);
      for (int i = 0; i < 17 && i < got_pos.size(); i++) begin
`ifdef PRIORITY_SCANNER_MSB_FIRST_EN
         chk("bffff_pos", got_pos[i], (i < 16) ? 15 - i : 0);
`else
         chk("bffff_pos", got_pos[i], (i < 16) ? i : 0);
`endif
         chk("bffff_last", got_last[i], (i == 15 || i == 16) ? 1 : 0);
      end

      // 0xF000, reset after the first beat is taken.
      got_pos.delete(); got_last.delete();
      send(16'hF000);
      step();
      chk("f000_first", (got_pos.size() > 0) ? got_pos[0] : -1,
`ifdef PRIORITY_SCANNER_MSB_FIRST_EN
          15);
`else
          12);
`endif
      async_reset();
      @(negedge clk);
      check_outputs();
      got_pos.delete(); got_last.delete();
      send(16'h0010);
      chk("b0010_pos",  int'(out_pos),  4);
      chk("b0010_last", int'(out_last), 1);
      drain(5);

      // Randomised traffic with occasional asynchronous reset.
      for (int c = 0; c < 3000; c++) begin
         int mode;
         mode      = $urandom_range(0, 7);
         in_valid  = ($urandom_range(0, 2) != 0);
         if (mode == 0)      in_vec = '0;
         else if (mode < 4)  in_vec = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
         else                in_vec = WIDTH'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 249) == 0) async_reset();
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain(40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/priority_scanner.md
Name: priority_scanner

Overview:
- Parametrised, sequential successor to the team's 4-bit lowest-set-bit priority encoder.
- Accepts a WIDTH-bit request vector over a valid/ready handshake.
- Emits the index of every set bit, one per output beat, lowest index first, clearing each bit as it is consumed.
- Used as the front end of interrupt/request servicing logic, where the consumer serves one request per beat and may stall.

Parameters:
- WIDTH, 16, width of the request vector; legal range 2..64.
- IDXW (localparam), $clog2(WIDTH), width of the index output.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a request vector is present on in_vec.
- in_ready  output  1  scanner can accept a vector; equals (state == IDLE).
- in_vec  input  WIDTH  request vector; bit i set = request i pending.
- out_valid  output  1  out_pos/out_last/out_none are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_pos  output  IDXW  index of the current lowest set bit of the residual vector.
- out_last  output  1  current beat is the final beat for this vector.
- out_none  output  1  accepted vector was all-zero; beat carries no index.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; residual register=0.
  - Outputs: out_valid=0, out_pos=0, out_last=0, out_none=0, busy=0, in_ready=1 (combinational from state).
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: out_valid=1, in_ready=0.
  - NONE: out_valid=1, out_none=1, out_last=1, out_pos=0, in_ready=0.
- Accept rule:
  - A vector is accepted on a rising edge where in_valid && in_ready.
  - Nonzero vector: residual<=in_vec, next state SCAN.
  - Zero vector: next state NONE.
  - in_valid while busy is ignored; the vector is not captured and no state changes.
- Latency:
  - First beat is valid the cycle after acceptance (1-cycle latency).
  - With out_ready held high, one beat per cycle, no bubbles.
- SCAN outputs:
  - out_pos = index of the lowest set bit of residual (combinational decode of a registered residual).
  - out_last = 1 when residual has exactly one bit set.
- SCAN handshake: on out_valid && out_ready:
  - residual bit out_pos is cleared.
  - If out_last, go to IDLE (residual becomes 0). Otherwise stay in SCAN.
- NONE handshake: on out_ready, go to IDLE.
- Backpressure:
  - While out_valid && !out_ready, residual, out_pos, out_last and out_none hold stable.
  - out_valid does not drop until the beat is taken.
- Back-to-back vectors:
  - in_ready rises the cycle after the last beat is taken.
  - No same-cycle bypass of the final beat into a new acceptance; minimum vector-to-vector turnaround is 1 idle cycle.
- Reset mid-scan: remaining bits are discarded, outputs return to reset values immediately (asynchronous), state=IDLE.
- Beats per vector: a vector with k set bits produces exactly k beats (k>=1), or exactly 1 NONE beat (k=0).
- out_pos never exceeds WIDTH-1.

Optional Feature:
- Macro PRIORITY_SCANNER_MSB_FIRST_EN.
- Defined:
  - out_pos = index of the highest set bit of residual; beats are issued in descending index order.
  - out_last and out_none semantics are unchanged.
- Undefined (default): lowest-index-first order as described above.
- Port list and timing are identical in both builds.

Test Plan:
- WIDTH=16, in_vec=16'h0000 -> one beat next cycle: out_none=1, out_last=1, out_pos=0; then IDLE, in_ready=1.
- in_vec=16'h8421, out_ready=1 -> out_pos 0,5,10,15 on 4 consecutive cycles; out_last=1 only with 15; busy low the following cycle.
- in_vec=16'h0006, out_ready low for 3 cycles after out_valid rises -> out_pos=1 held stable for 3 cycles; then 1, 2 with out_last on 2.
- in_vec=16'hFFFF, out_ready=1, in_valid held high with 16'h0001 during the scan -> 16 beats 0..15; the second vector is accepted only after IDLE and yields a single beat pos=0, last=1.
- in_vec=16'hF000, assert rst after the beat pos=12 is taken -> out_valid=0 and in_ready=1 asynchronously; the next vector 16'h0010 yields pos=4, last=1.
- Build with PRIORITY_SCANNER_MSB_FIRST_EN, in_vec=16'h8421 -> out_pos 15,10,5,0; out_last with 0.
